tile_layer_sequencer: RTL and testbench
=======================================

# tile_layer_sequencer

Per-scanline controller for the tile layers. On each line start it steps `current_layer` through every layer, reads the selected layer's decoded register fields, and issues one tile-map fetch request per visible tile column on a req/ack port to the tile map memory. It drives the tile register decoder's layer select and sits between the video timing generator and the shared tile-map memory port.

## Interface

**Clocking and reset.** One clock `clk`. Reset `reset` is synchronous and active-high.

**Parameters**
- `NUM_LAYERS`, 4: number of tile layers. Must match the tile register file.
- `TILES_PER_LINE`, 21: fetches issued per enabled layer per line.
- `TILE_SIZE_LOG2`, 4: tile edge is 16 pixels.
- `MAP_W_LOG2`, 5: map width is 32 tiles. Must be a power of two.
- `MAP_H_LOG2`, 5: map height is 32 tiles. Must be a power of two.
- `REG_DATA_WIDTH`, 16: register field and address width.

**Ports**
- `clk`, in, 1: clock.
- `reset`, in, 1: synchronous, active-high.
- `line_start`, in, 1: one-cycle pulse that begins a line.
- `screen_y`, in, 10: line number, sampled on `line_start`.
- `current_layer`, out, 2: layer select to the register decoder.
- `layer_enabled`, in, 1: decoded field for `current_layer`.
- `enable_scroll`, in, 1: decoded field for `current_layer`.
- `data_offset`, in, 16: decoded field for `current_layer`.
- `offset_x`, in, 16: decoded field for `current_layer`.
- `offset_y`, in, 16: decoded field for `current_layer`.
- `mem_req`, out, 1: fetch request valid.
- `mem_addr`, out, 16: tile-map word address.
- `mem_layer`, out, 2: layer tag for the fetch.
- `mem_col`, out, 5: column index within the line, 0..`TILES_PER_LINE`-1.
- `mem_ack`, in, 1: memory accepts the request this cycle.
- `busy`, out, 1: high in any state other than IDLE.
- `line_done`, out, 1: one-cycle pulse when all layers are finished.
- `overrun`, out, 1: sticky flag; cleared only by `reset`.

## Operation

**States:** IDLE, SELECT, FETCH, DONE.

**IDLE**
- On `line_start`: latch `screen_y`, set `current_layer` to 0, go to SELECT.

**SELECT** (one cycle per layer; decoder outputs are combinational from `current_layer`)
- If `layer_enabled`:
  - Latch `data_offset`.
  - Compute row base: `row = ((y + (enable_scroll ? offset_y : 0)) >> TILE_SIZE_LOG2) & (2^MAP_H_LOG2 - 1)`.
  - Compute column base: `colbase = enable_scroll ? offset_x >> TILE_SIZE_LOG2 : 0`.
  - Clear the column counter and go to FETCH.
- If not enabled:
  - If this is the last layer, go to DONE.
  - Otherwise increment `current_layer` and stay in SELECT.

**FETCH**
- `mem_req` stays high.
- `mem_addr = data_offset + (row << MAP_W_LOG2) + ((colbase + col) & (2^MAP_W_LOG2 - 1))`, truncated to 16 bits (modulo 2^16).
- `mem_layer = current_layer`, `mem_col = col`.
- `mem_addr`, `mem_layer` and `mem_col` hold stable until `mem_ack`.
- On `mem_ack`, increment `col`.
- On the ack for `col == TILES_PER_LINE-1`:
  - If this is the last layer, go to DONE.
  - Otherwise increment `current_layer` and go to SELECT.

**DONE**
- `line_done` is high for one cycle, then go to IDLE.

**Boundary conditions**
- Horizontal wrap: a scroll column past 31 wraps to 0 within the same row.
- Vertical wrap: a row past 31 wraps to 0.
- `line_start` while `busy`:
  - Set `overrun`.
  - Abort the current line with no `line_done`.
  - Latch the new `screen_y`, set layer 0, enter SELECT next cycle.
  - `mem_req` drops in that same next cycle. A `mem_ack` arriving in the abort cycle is ignored.
- `mem_ack` while `mem_req` is low: ignored.
- `reset` mid-line: next cycle is IDLE with all outputs at reset values. No `line_done`.

## Timing

**Reset values:**
- State is IDLE.
- `current_layer` = 0.
- `mem_req`, `busy`, `line_done`, `overrun` = 0.
- `mem_addr`, `mem_layer`, `mem_col` = 0.

**Latency and throughput**
- All outputs are registered.
- `line_start` sampled at cycle 0 puts layer 0 in SELECT at cycle 1.
- For an enabled layer, the first `mem_req` appears the cycle after its SELECT.
- Peak throughput is one fetch per cycle when `mem_ack` is held high. An enabled layer then takes 1 + `TILES_PER_LINE` cycles.
- Each disabled layer costs one SELECT cycle.
- All layers disabled: SELECT in cycles 1–4, `line_done` in cycle 5.

## Structure

**Shared `tile_registers` header:**
- Layer count.
- Map dimension log2 values.
- Tile size log2.
- State encoding constants.

**Sub-modules:**
- None required.
- Optional: `tile_map_addr_gen`, a combinational row/column/offset address arithmetic unit, so the wrap math can be unit-tested in isolation.

## Test plan

- **All enabled, zero offsets, `mem_ack` tied high.** `line_start` with y=35 and `data_offset` 0x1000 on every layer produces 84 requests. Layer 0 addresses run 0x1040..0x1054. `line_done` fires at cycle 1 + 4×22.
- **Scroll wrap.** Layer 1 only, scroll on, `offset_x`=0x1E0, `offset_y`=0x1F8, y=16, offset 0. Row = (16+504)>>4 = 32&31 = 0. Columns run 30, 31, 0..18, giving addresses 0x1E, 0x1F, 0x00...
- **All layers disabled.** `line_done` at cycle 5, `mem_req` never asserted, `busy` high in cycles 1–5.
- **Ack backpressure.** `mem_ack` is asserted only every third cycle. `mem_addr`, `mem_layer` and `mem_col` stay stable while unacked, and no column is skipped or duplicated.
- **Overrun.** A second `line_start` during layer 2 FETCH sets `overrun`. The next cycle shows SELECT with layer 0 and `mem_req` low, and there is no `line_done` for the aborted line.
- **Reset in FETCH.** `mem_req` is 0 and `busy` is 0 the next cycle, `overrun` is cleared, and there is no `line_done`.

Source files
------------

// File: rtl/tile_layer_sequencer_pkg.sv
// Shared tile-layer definitions for the tile layer sequencer.
//   - Default layer count, map and tile geometry (log2 values).
//   - Port widths for the layer select and the column index.
//   - State encoding for the per-line sequencing FSM.
package tile_layer_sequencer_pkg;

    localparam int NUM_LAYERS_DEF     = 4;
    localparam int TILES_PER_LINE_DEF = 21;
    localparam int TILE_SIZE_LOG2_DEF = 4;
    localparam int MAP_W_LOG2_DEF     = 5;
    localparam int MAP_H_LOG2_DEF     = 5;
    localparam int REG_WIDTH_DEF      = 16;

    localparam int LAYER_W = 2;
    localparam int COL_W   = 5;
    localparam int Y_W     = 10;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_FETCH  = 2'd2,
        ST_DONE   = 2'd3
    } seq_state_e;

endpackage

// File: rtl/tile_layer_sequencer.sv
// Per-scanline tile layer sequencer.
// On each line_start it walks current_layer through every layer, samples
// that layer's decoded register fields, and for each enabled layer issues
// TILES_PER_LINE tile-map fetches on a req/ack port. All outputs registered.
// Ports:
//   clk, reset (sync, active-high)
//   line_start, screen_y            : line timing from the video timing generator
//   current_layer                   : layer select to the register decoder
//   layer_enabled, enable_scroll,
//   data_offset, offset_x, offset_y : decoded fields for current_layer
//   mem_req, mem_addr, mem_layer,
//   mem_col, mem_ack                : tile-map fetch port
//   busy, line_done, overrun        : status
module tile_layer_sequencer
    import tile_layer_sequencer_pkg::*;
#(
    parameter int NUM_LAYERS     = NUM_LAYERS_DEF,
    parameter int TILES_PER_LINE = TILES_PER_LINE_DEF,
    parameter int TILE_SIZE_LOG2 = TILE_SIZE_LOG2_DEF,
    parameter int MAP_W_LOG2     = MAP_W_LOG2_DEF,
    parameter int MAP_H_LOG2     = MAP_H_LOG2_DEF,
    parameter int REG_DATA_WIDTH = REG_WIDTH_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      line_start,
    input  logic [Y_W-1:0]            screen_y,
    output logic [LAYER_W-1:0]        current_layer,
    input  logic                      layer_enabled,
    input  logic                      enable_scroll,
    input  logic [REG_DATA_WIDTH-1:0] data_offset,
    input  logic [REG_DATA_WIDTH-1:0] offset_x,
    input  logic [REG_DATA_WIDTH-1:0] offset_y,
    output logic                      mem_req,
    output logic [REG_DATA_WIDTH-1:0] mem_addr,
    output logic [LAYER_W-1:0]        mem_layer,
    output logic [COL_W-1:0]          mem_col,
    input  logic                      mem_ack,
    output logic                      busy,
    output logic                      line_done,
    output logic                      overrun
);

    localparam int RW = REG_DATA_WIDTH;
    localparam logic [RW-1:0]      MAP_W_MASK = RW'((32'd1 << MAP_W_LOG2) - 32'd1);
    localparam logic [RW-1:0]      MAP_H_MASK = RW'((32'd1 << MAP_H_LOG2) - 32'd1);
    localparam logic [LAYER_W-1:0] LAST_LAYER = LAYER_W'(NUM_LAYERS - 1);
    localparam logic [LAYER_W-1:0] LAYER_ONE  = LAYER_W'(32'd1);
    localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(TILES_PER_LINE - 1);
    localparam logic [COL_W-1:0]   COL_ONE    = COL_W'(32'd1);

    // Row and column bases are kept at full register width and wrapped here,
    // so the map wraps in both directions with plain masking.
    function automatic logic [RW-1:0] tile_addr(
        input logic [RW-1:0]    base,
        input logic [RW-1:0]    row_full,
        input logic [RW-1:0]    colbase_full,
        input logic [COL_W-1:0] col
    );
        logic [RW-1:0] row_w;
        logic [RW-1:0] col_w;
        row_w = row_full & MAP_H_MASK;
        col_w = (colbase_full + RW'(col)) & MAP_W_MASK;
        return base + (row_w << MAP_W_LOG2) + col_w;
    endfunction

    seq_state_e          state_r, state_nxt_s;
    logic [Y_W-1:0]      y_r, y_nxt_s;
    logic [LAYER_W-1:0]  layer_r, layer_nxt_s;
    logic [RW-1:0]       base_r, base_nxt_s;
    logic [RW-1:0]       row_r, row_nxt_s;
    logic [RW-1:0]       colbase_r, colbase_nxt_s;
    logic [COL_W-1:0]    col_r, col_nxt_s;
    logic [RW-1:0]       addr_r, addr_nxt_s;
    logic [LAYER_W-1:0]  mem_layer_r, mem_layer_nxt_s;
    logic                req_r, req_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                done_r, done_nxt_s;
    logic                overrun_r, overrun_nxt_s;
    logic [RW-1:0]       ysum_s;
    logic [RW-1:0]       sel_row_s;
    logic [RW-1:0]       sel_colbase_s;

    assign ysum_s        = RW'(y_r) + (enable_scroll ? offset_y : {RW{1'b0}});
    assign sel_row_s     = ysum_s >> TILE_SIZE_LOG2;
    assign sel_colbase_s = enable_scroll ? (offset_x >> TILE_SIZE_LOG2) : {RW{1'b0}};

    // Next-state and next-output computation for the line sequencer
    always_comb begin
        state_nxt_s     = state_r;
        y_nxt_s         = y_r;
        layer_nxt_s     = layer_r;
        base_nxt_s      = base_r;
        row_nxt_s       = row_r;
        colbase_nxt_s   = colbase_r;
        col_nxt_s       = col_r;
        addr_nxt_s      = addr_r;
        mem_layer_nxt_s = mem_layer_r;
        overrun_nxt_s   = overrun_r;

        if (line_start && (state_r != ST_IDLE)) begin
            // New line arrived before the old one finished: abort and restart.
            overrun_nxt_s = 1'b1;
            y_nxt_s       = screen_y;
            layer_nxt_s   = {LAYER_W{1'b0}};
            state_nxt_s   = ST_SELECT;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (line_start) begin
                        y_nxt_s     = screen_y;
                        layer_nxt_s = {LAYER_W{1'b0}};
                        state_nxt_s = ST_SELECT;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SELECT: begin
                    if (layer_enabled) begin
                        base_nxt_s      = data_offset;
                        row_nxt_s       = sel_row_s;
                        colbase_nxt_s   = sel_colbase_s;
                        col_nxt_s       = {COL_W{1'b0}};
                        addr_nxt_s      = tile_addr(data_offset, sel_row_s, sel_colbase_s, {COL_W{1'b0}});
                        mem_layer_nxt_s = layer_r;
                        state_nxt_s     = ST_FETCH;
                    end else if (layer_r == LAST_LAYER) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        layer_nxt_s = layer_r + LAYER_ONE;
                    end
                end
                ST_FETCH: begin
                    if (mem_ack) begin
                        if (col_r == LAST_COL) begin
                            if (layer_r == LAST_LAYER) begin
                                state_nxt_s = ST_DONE;
                            end else begin
                                layer_nxt_s = layer_r + LAYER_ONE;
                                state_nxt_s = ST_SELECT;
                            end
                        end else begin
                            col_nxt_s  = col_r + COL_ONE;
                            addr_nxt_s = tile_addr(base_r, row_r, colbase_r, col_r + COL_ONE);
                        end
                    end else begin
                        state_nxt_s = ST_FETCH;
                    end
                end
                ST_DONE: begin
                    state_nxt_s = ST_IDLE;
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end

        req_nxt_s  = (state_nxt_s == ST_FETCH);
        busy_nxt_s = (state_nxt_s != ST_IDLE);
        done_nxt_s = (state_nxt_s == ST_DONE);
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            y_r         <= {Y_W{1'b0}};
            layer_r     <= {LAYER_W{1'b0}};
            base_r      <= {RW{1'b0}};
            row_r       <= {RW{1'b0}};
            colbase_r   <= {RW{1'b0}};
            col_r       <= {COL_W{1'b0}};
            addr_r      <= {RW{1'b0}};
            mem_layer_r <= {LAYER_W{1'b0}};
            req_r       <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            y_r         <= y_nxt_s;
            layer_r     <= layer_nxt_s;
            base_r      <= base_nxt_s;
            row_r       <= row_nxt_s;
            colbase_r   <= colbase_nxt_s;
            col_r       <= col_nxt_s;
            addr_r      <= addr_nxt_s;
            mem_layer_r <= mem_layer_nxt_s;
            req_r       <= req_nxt_s;
            busy_r      <= busy_nxt_s;
            done_r      <= done_nxt_s;
            overrun_r   <= overrun_nxt_s;
        end
    end

    assign current_layer = layer_r;
    assign mem_req       = req_r;
    assign mem_addr      = addr_r;
    assign mem_layer     = mem_layer_r;
    assign mem_col       = col_r;
    assign busy          = busy_r;
    assign line_done     = done_r;
    assign overrun       = overrun_r;

endmodule

// File: tb/tb_tile_layer_sequencer.sv
// Self-checking bench for tile_layer_sequencer: a behavioural line model
// predicts every output each cycle; directed lines pin literal values.
module tb_tile_layer_sequencer;

    localparam int M_IDLE = 0, M_SEL = 1, M_FETCH = 2, M_DONE = 3;

    logic        clk = 1'b0;
    logic        reset, line_start, mem_ack;
    logic [9:0]  screen_y;
    logic [1:0]  current_layer, mem_layer;
    logic        layer_enabled, enable_scroll;
    logic [15:0] data_offset, offset_x, offset_y, mem_addr;
    logic        mem_req, busy, line_done, overrun;
    logic [4:0]  mem_col;

    always #5 clk = ~clk;

    tile_layer_sequencer dut (
        .clk(clk), .reset(reset), .line_start(line_start), .screen_y(screen_y),
        .current_layer(current_layer), .layer_enabled(layer_enabled),
        .enable_scroll(enable_scroll), .data_offset(data_offset),
        .offset_x(offset_x), .offset_y(offset_y), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_layer(mem_layer), .mem_col(mem_col),
        .mem_ack(mem_ack), .busy(busy), .line_done(line_done), .overrun(overrun)
    );

    // Register file contents seen through the decoder
    bit          t_en[4];
    bit          t_scr[4];
    logic [15:0] t_off[4], t_ox[4], t_oy[4];

    always_comb begin
        layer_enabled = t_en[current_layer];
        enable_scroll = t_scr[current_layer];
        data_offset   = t_off[current_layer];
        offset_x      = t_ox[current_layer];
        offset_y      = t_oy[current_layer];
    end

    typedef struct { int l; int c; int a; } acc_t;
    acc_t acc_q[$];

    int m_mode = M_IDLE, m_layer = 0, m_col = 0, m_y = 0;
    bit m_ovr = 1'b0;
    int total = 0, bad = 0, cyc = 0, ls_edge = 0, done_rel = -1, n_done = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int exp_addr(input int l, input int col);
        int yy, row, cb;
        yy  = m_y + (t_scr[l] ? int'(t_oy[l]) : 0);
        row = (yy / 16) % 32;
        cb  = t_scr[l] ? (int'(t_ox[l]) / 16) : 0;
        return (int'(t_off[l]) + row * 32 + ((cb + col) % 32)) % 65536;
    endfunction

    task automatic model_step(input bit r, input bit ls, input int sy, input bit ack);
        if (r) begin
            m_mode = M_IDLE; m_layer = 0; m_col = 0; m_ovr = 1'b0;
        end else if (ls && m_mode != M_IDLE) begin
            m_ovr = 1'b1; m_y = sy; m_layer = 0; m_mode = M_SEL;
        end else if (m_mode == M_IDLE) begin
            if (ls) begin m_y = sy; m_layer = 0; m_mode = M_SEL; end
        end else if (m_mode == M_SEL) begin
            if (t_en[m_layer]) begin m_col = 0; m_mode = M_FETCH; end
            else if (m_layer == 3) m_mode = M_DONE;
            else m_layer++;
        end else if (m_mode == M_FETCH) begin
            if (ack) begin
                if (m_col == 20) begin
                    if (m_layer == 3) m_mode = M_DONE;
                    else begin m_layer++; m_mode = M_SEL; end
                end else m_col++;
            end
        end else begin
            m_mode = M_IDLE;
        end
    endtask

    task automatic compare_all();
        chk("busy", int'(busy), int'(m_mode != M_IDLE));
        chk("line_done", int'(line_done), int'(m_mode == M_DONE));
        chk("mem_req", int'(mem_req), int'(m_mode == M_FETCH));
        chk("current_layer", int'(current_layer), m_layer);
        chk("overrun", int'(overrun), int'(m_ovr));
        if (m_mode == M_FETCH) begin
            chk("mem_addr", int'(mem_addr), exp_addr(m_layer, m_col));
            chk("mem_layer", int'(mem_layer), m_layer);
            chk("mem_col", int'(mem_col), m_col);
        end
    endtask

    // One clock: drive inputs at the falling edge, step model, compare next falling edge
    task automatic tick(input bit r, input bit ls, input logic [9:0] sy, input bit ack);
        reset = r; line_start = ls; screen_y = sy; mem_ack = ack;
        if (mem_req && ack && !r && !ls)
            acc_q.push_back('{int'(mem_layer), int'(mem_col), int'(mem_addr)});
        @(posedge clk);
        cyc++;
        if (ls && !r) ls_edge = cyc;
        model_step(r, ls, int'(sy), ack);
        @(negedge clk);
        compare_all();
        if (line_done) begin
            done_rel = cyc - ls_edge + 1;
            n_done++;
        end
    endtask

    function automatic bit pick_ack(input int mode);
        if (mode == 0) return 1'b1;
        else if (mode == 1) return (cyc % 3) == 0;
        else return 1'($urandom_range(0, 1));
    endfunction

    task automatic run_line(input int y, input int ack_mode);
        int start_done;
        bit fin;
        acc_q.delete();
        start_done = n_done;
        fin = 1'b0;
        tick(1'b0, 1'b1, 10'(y), 1'b1);
        for (int i = 0; i < 2000 && !fin; i++) begin
            tick(1'b0, 1'b0, 10'd0, pick_ack(ack_mode));
            if (n_done != start_done) fin = 1'b1;
        end
        chk("line_finished", int'(fin), 1);
    endtask

    task automatic set_layer(input int l, input bit en, input bit scr,
                             input logic [15:0] off, input logic [15:0] ox, input logic [15:0] oy);
        t_en[l] = en; t_scr[l] = scr; t_off[l] = off; t_ox[l] = ox; t_oy[l] = oy;
    endtask

    task automatic run_until_fetch(input int layer, input int col);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < 500 && !hit; i++) begin
            if (m_mode == M_FETCH && m_layer == layer && m_col == col) hit = 1'b1;
            else tick(1'b0, 1'b0, 10'd0, 1'b1);
        end
        chk("reach_fetch", int'(hit), 1);
    endtask

    initial begin
        int nd;
        bit rr, ls;
        int roll;
        reset = 1'b1; line_start = 1'b0; screen_y = 10'd0; mem_ack = 1'b0;
        for (int l = 0; l < 4; l++) set_layer(l, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        @(negedge clk);
        tick(1'b1, 1'b0, 10'd0, 1'b1);
        tick(1'b1, 1'b0, 10'd0, 1'b0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_layer", int'(mem_layer), 0);
        chk("rst_mem_col", int'(mem_col), 0);
        chk("rst_busy", int'(busy), 0);
        tick(1'b0, 1'b0, 10'd0, 1'b0);

        // All layers enabled, zero offsets, ack held high
        for (int l = 0; l < 4; l++) set_layer(l, 1'b1, 1'b0, 16'h1000, 16'h0, 16'h0);
        run_line(35, 0);
        chk("t1_done_cycle", done_rel, 89);
        chk("t1_req_count", acc_q.size(), 84);
        if (acc_q.size() == 84) begin
            chk("t1_first_addr", acc_q[0].a, 32'h1040);
            chk("t1_l0_last_addr", acc_q[20].a, 32'h1054);
            chk("t1_l1_layer", acc_q[21].l, 1);
        end

        // Scroll wrap on layer 1 only
        for (int l = 0; l < 4; l++) set_layer(l, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        set_layer(1, 1'b1, 1'b1, 16'h0000, 16'h01E0, 16'h01F8);
        run_line(16, 0);
        chk("t2_req_count", acc_q.size(), 21);
        chk("t2_done_cycle", done_rel, 26);
        if (acc_q.size() == 21) begin
            chk("t2_addr0", acc_q[0].a, 32'h1E);
            chk("t2_addr1", acc_q[1].a, 32'h1F);
            chk("t2_addr2", acc_q[2].a, 32'h00);
            chk("t2_addr20", acc_q[20].a, 32'h12);
            chk("t2_layer", acc_q[0].l, 1);
        end

        // All layers disabled
        set_layer(1, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
        run_line(200, 0);
        chk("t3_done_cycle", done_rel, 5);
        chk("t3_req_count", acc_q.size(), 0);

        // Backpressure: ack every third cycle, random register contents
        for (int l = 0; l < 4; l++)
            set_layer(l, 1'b1, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'($urandom));
        run_line(777, 1);
        chk("t4_req_count", acc_q.size(), 84);
        foreach (acc_q[i]) begin
            chk("t4_col_seq", acc_q[i].c, i % 21);
            chk("t4_layer_seq", acc_q[i].l, i / 21);
        end

        // Overrun during layer 2 fetch
        for (int l = 0; l < 4; l++) set_layer(l, 1'b1, 1'b0, 16'h2000, 16'h0, 16'h0);
        nd = n_done;
        tick(1'b0, 1'b1, 10'd40, 1'b1);
        run_until_fetch(2, 5);
        tick(1'b0, 1'b1, 10'd100, 1'b1);
        chk("t5_overrun", int'(overrun), 1);
        chk("t5_layer0", int'(current_layer), 0);
        chk("t5_req_low", int'(mem_req), 0);
        chk("t5_busy", int'(busy), 1);
        for (int i = 0; i < 200 && n_done == nd; i++) tick(1'b0, 1'b0, 10'd0, 1'b1);
        chk("t5_one_done", n_done - nd, 1);

        // Reset during fetch
        nd = n_done;
        tick(1'b0, 1'b1, 10'd7, 1'b1);
        run_until_fetch(0, 3);
        tick(1'b1, 1'b0, 10'd0, 1'b1);
        chk("t6_req", int'(mem_req), 0);
        chk("t6_busy", int'(busy), 0);
        chk("t6_overrun", int'(overrun), 0);
        chk("t6_done", int'(line_done), 0);
        for (int i = 0; i < 30; i++) tick(1'b0, 1'b0, 10'd0, 1'b0);
        chk("t6_no_done", n_done - nd, 0);

        // Randomized lines with random ack, occasional overrun and reset
        for (int i = 0; i < 8000; i++) begin
            roll = $urandom_range(0, 999);
            rr = (roll < 2);
            ls = 1'b0;
            if (!rr && m_mode == M_IDLE && $urandom_range(0, 3) == 0) begin
                for (int l = 0; l < 4; l++)
                    set_layer(l, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                              16'($urandom), 16'($urandom), 16'($urandom));
                ls = 1'b1;
            end else if (!rr && m_mode != M_IDLE && roll < 5) begin
                ls = 1'b1;
            end
            tick(rr, ls, 10'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
